module_spi_xfer_ctrl: RTL

//  SPI master transfer sequencer; the read side of the control/data register pair.
//  - Each cycle, reads the 32-bit control word and the 32-bit data word at data_addr_o.
//  - Shifts 8-bit frames out on MOSI (mode 0, MSB first) and captures MISO.
//  - Writes received bytes back to the data register and updates the control word on completion.

---
 rtl/spi_ctrl_pkg.sv | 41 ++++
 rtl/module_spi_sclk_gen.sv | 45 ++++
 rtl/module_spi_xfer_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/spi_ctrl_pkg.sv
// Shared types and field positions for the SPI transfer sequencer.
// Optional SPI_LOOPBACK_EN (set by the build) is consumed by module_spi_xfer_ctrl.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SHIFT  = 3'd2,
    STORE  = 3'd3,
    UPDATE = 3'd4
  } state_t;

  localparam int CTRL_SEND    = 0;
  localparam int CTRL_ALL1    = 1;
  localparam int CTRL_ALL0    = 2;
  localparam int CTRL_NTX_LSB = 4;
  localparam int CTRL_NTX_MSB = 12;
  localparam int CTRL_NRX_LSB = 16;
  localparam int CTRL_NRX_MSB = 25;
  localparam int FRAME_W      = 8;

  // all_1s wins over all_0s; otherwise the stored byte goes out
  function automatic logic [FRAME_W-1:0] tx_pattern(input logic all1,
                                                    input logic all0,
                                                    input logic [FRAME_W-1:0] data);
    logic [FRAME_W-1:0] res;
    if (all1) begin
      res = 8'hFF;
    end else if (all0) begin
      res = 8'h00;
    end else begin
      res = data;
    end
    return res;
  endfunction

  function automatic logic [9:0] frames_done(input logic [8:0] n_tx_end);
    return {1'b0, n_tx_end} + 10'd1;
  endfunction

endpackage

// File: rtl/module_spi_sclk_gen.sv
// SCLK generator: toggles every HALF_DIV clocks while run_i is high,
// with one-clock rise/fall pulses aligned to the registered sclk_o edge.
module module_spi_sclk_gen #(
  parameter int HALF_DIV = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = $clog2(HALF_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_DIV - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             sclk_r;
  logic             rise_r;
  logic             fall_r;

  // half-period counter; parked low and cleared whenever not running
  always_ff @(posedge clk_i) begin
    if (rst_i || !run_i) begin
      cnt_r  <= '0;
      sclk_r <= 1'b0;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r  <= '0;
      sclk_r <= ~sclk_r;
      rise_r <= ~sclk_r;
      fall_r <= sclk_r;
    end else begin
      cnt_r  <= cnt_r + CNT_W'(1);
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end
  end

  assign sclk_o = sclk_r;
  assign rise_o = rise_r;
  assign fall_o = fall_r;

endmodule

// File: rtl/module_spi_xfer_ctrl.sv
// SPI master transfer sequencer (mode 0, MSB first) over a control/data register pair.
// Build option SPI_LOOPBACK_EN: rx samples mosi_o internally and miso_i is ignored.
module module_spi_xfer_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int HALF_DIV = 5,
  parameter int ADDR_W   = 9
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       ctrl_i,
  output logic [31:0]       ctrl_o,
  output logic              ctrl_wr_o,
  input  logic [31:0]       data_i,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [31:0]       data_o,
  output logic              data_wr_o,
  output logic              sclk_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic              cs_o
);

  state_t              state_r;
  state_t              state_s;
  logic [8:0]          ntx_r;
  logic                all1_r;
  logic                all0_r;
  logic [31:0]         ctrl_lat_r;
  logic [2:0]          bit_cnt_r;
  logic [FRAME_W-1:0]  tx_r;
  logic [FRAME_W-1:0]  rx_r;
  logic [FRAME_W-1:0]  tx_byte_s;
  logic                holdoff_r;
  logic                cs_r;
  logic                mosi_r;
  logic                ctrl_wr_r;
  logic                data_wr_r;
  logic [ADDR_W-1:0]   data_addr_r;
  logic [31:0]         data_r;
  logic [31:0]         ctrl_r;
  logic                send_s;
  logic                last_fall_s;
  logic                last_frame_s;
  logic                rx_bit_s;
  logic                run_s;
  logic                sclk_s;
  logic                rise_s;
  logic                fall_s;
  logic                unused_s;

  module_spi_sclk_gen #(.HALF_DIV(HALF_DIV)) u_sclk_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .run_i  (run_s),
    .sclk_o (sclk_s),
    .rise_o (rise_s),
    .fall_o (fall_s)
  );

`ifdef SPI_LOOPBACK_EN
  assign rx_bit_s = mosi_r;
  assign unused_s = ^{data_i[31:FRAME_W], miso_i};
`else
  assign rx_bit_s = miso_i;
  assign unused_s = ^data_i[31:FRAME_W];
`endif

  // holdoff masks a send bit whose clearing write has not landed yet
  assign send_s       = ctrl_i[CTRL_SEND] && !holdoff_r;
  assign run_s        = (state_r == SHIFT);
  assign last_fall_s  = fall_s && (bit_cnt_r == 3'd7);
  assign last_frame_s = (data_addr_r == ntx_r[ADDR_W-1:0]);
  assign tx_byte_s    = tx_pattern(all1_r, all0_r, data_i[FRAME_W-1:0]);

  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (send_s) state_s = LOAD;
        else        state_s = IDLE;
      end
      LOAD:  state_s = SHIFT;
      SHIFT: begin
        if (last_fall_s) state_s = STORE;
        else             state_s = SHIFT;
      end
      STORE: begin
        if (last_frame_s) state_s = UPDATE;
        else              state_s = LOAD;
      end
      UPDATE:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // datapath and registered outputs; write strobes default low every cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ntx_r       <= 9'd0;
      all1_r      <= 1'b0;
      all0_r      <= 1'b0;
      ctrl_lat_r  <= 32'd0;
      bit_cnt_r   <= 3'd0;
      tx_r        <= '0;
      rx_r        <= '0;
      holdoff_r   <= 1'b0;
      cs_r        <= 1'b1;
      mosi_r      <= 1'b0;
      ctrl_wr_r   <= 1'b0;
      data_wr_r   <= 1'b0;
      data_addr_r <= '0;
      data_r      <= 32'd0;
      ctrl_r      <= 32'd0;
    end else begin
      ctrl_wr_r <= 1'b0;
      data_wr_r <= 1'b0;
      case (state_r)
        IDLE: begin
          holdoff_r <= 1'b0;
          if (send_s) begin
            ntx_r       <= ctrl_i[CTRL_NTX_MSB:CTRL_NTX_LSB];
            all1_r      <= ctrl_i[CTRL_ALL1];
            all0_r      <= ctrl_i[CTRL_ALL0];
            ctrl_lat_r  <= ctrl_i;
            data_addr_r <= '0;
            cs_r        <= 1'b0;
          end
        end
        LOAD: begin
          tx_r      <= tx_byte_s;
          mosi_r    <= tx_byte_s[FRAME_W-1];
          rx_r      <= '0;
          bit_cnt_r <= 3'd0;
        end
        SHIFT: begin
          if (rise_s) begin
            rx_r <= {rx_r[FRAME_W-2:0], rx_bit_s};
          end
          if (fall_s) begin
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r != 3'd7) begin
              tx_r   <= {tx_r[FRAME_W-2:0], 1'b0};
              mosi_r <= tx_r[FRAME_W-2];
            end else begin
              data_r    <= {24'h000000, rx_r};
              data_wr_r <= 1'b1;
            end
          end
        end
        STORE: begin
          if (!last_frame_s) begin
            data_addr_r <= data_addr_r + ADDR_W'(1);
          end else begin
            ctrl_r    <= {ctrl_lat_r[31:CTRL_NRX_MSB+1], frames_done(ntx_r),
                          ctrl_lat_r[CTRL_NRX_LSB-1:CTRL_SEND+1], 1'b0};
            ctrl_wr_r <= 1'b1;
          end
        end
        UPDATE: begin
          cs_r      <= 1'b1;
          holdoff_r <= 1'b1;
        end
        default: begin
          cs_r <= 1'b1;
        end
      endcase
    end
  end

  assign ctrl_o      = ctrl_r;
  assign ctrl_wr_o   = ctrl_wr_r;
  assign data_addr_o = data_addr_r;
  assign data_o      = data_r;
  assign data_wr_o   = data_wr_r;
  assign sclk_o      = sclk_s;
  assign mosi_o      = mosi_r;
  assign cs_o        = cs_r;

endmodule
